// File: rtl/memory_if.sv
// Word-memory access bus: one shared address, write data/enable, registered read data.
// Latency: data_out follows address by one clk edge. No backpressure; one op per cycle.
interface memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  we;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output address,
    output data,
    output we,
    input  data_out
  );

  modport slave (
    input  address,
    input  data,
    input  we,
    output data_out
  );
endinterface

// File: rtl/memory.sv
// Single-port 2**ADDR_WIDTH x DATA_WIDTH data store, async-reset to all zero; MEMORY_WRITE_THROUGH_EN selects write-through.
// Latency: 1 cycle read (registered), write visible to the read on the next edge.
// Backpressure: none; one read (plus optional write) every cycle.
module memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  memory_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_q;

  // The whole array is cleared on reset so the store never exposes stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_dat_q <= '0;
    end else begin
      if (bus.we) begin
        mem[bus.address] <= bus.data;
      end
`ifdef MEMORY_WRITE_THROUGH_EN
      rd_dat_q <= bus.we ? bus.data : mem[bus.address];
`else
      rd_dat_q <= mem[bus.address];
`endif
    end
  end

  assign bus.data_out = rd_dat_q;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: a reference array predicts data_out for every driven op.
// Expected words are queued at drive time and popped one edge later by the monitor.
`timescale 1ns/1ps
module tb_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  memory #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: data_out=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one op before the next edge and queue the word data_out must show after it.
  task automatic do_op(input string tag, input logic [7:0] a, input logic w, input logic [31:0] d);
    logic [31:0] e;
    @(negedge clk);
    bus.address = a;
    bus.data    = d;
    bus.we      = w;
`ifdef MEMORY_WRITE_THROUGH_EN
    e = w ? d : model[a];
`else
    e = model[a];
`endif
    if (w) model[a] = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), bus.data_out, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] vals [8];
    vals[0] = 32'd1;      vals[1] = 32'd10;      vals[2] = 32'd100;     vals[3] = 32'd1000;
    vals[4] = 32'd10000;  vals[5] = 32'd100000;  vals[6] = 32'd1000000; vals[7] = 32'd10000000;

    for (int i = 0; i < 256; i++) model[i] = '0;
    bus.address = '0;
    bus.data    = '0;
    bus.we      = 1'b0;

    #1 rst_n = 1'b0;
    #2 check("reset_out", bus.data_out, 32'h0);
    @(negedge clk);
    bus.we = 1'b1;
    bus.data = 32'hA5A5A5A5;
    @(posedge clk);
    #1 check("reset_hold", bus.data_out, 32'h0);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n = 1'b1;

    do_op("rd_rst_0",   8'd0,   1'b0, 32'h0);
    do_op("rd_rst_7",   8'd7,   1'b0, 32'h0);
    do_op("rd_rst_255", 8'd255, 1'b0, 32'h0);
    // The write attempted under reset must not have landed at address 0.
    do_op("rd_rst_we",  8'd0,   1'b0, 32'h0);

    for (int i = 0; i < 8; i++) do_op("wr_seq", 8'(i), 1'b1, vals[i]);
    for (int i = 0; i < 8; i++) do_op("rd_seq", 8'(i), 1'b0, 32'h0);

    do_op("wr_5",      8'd5, 1'b1, 32'd102);
    do_op("rd_5",      8'd5, 1'b0, 32'h0);
    do_op("rd_4",      8'd4, 1'b0, 32'h0);

    do_op("rdw_3",     8'd3, 1'b1, 32'hDEADBEEF);
    do_op("rd_3",      8'd3, 1'b0, 32'h0);

    do_op("wr_255",    8'd255, 1'b1, 32'hFFFFFFFF);
    do_op("rd_255",    8'd255, 1'b0, 32'h0);
    do_op("rd_0",      8'd0,   1'b0, 32'h0);

    do_op("wr_b2b",    8'd9, 1'b1, 32'h11111111);
    do_op("wr_b2b",    8'd9, 1'b1, 32'h22222222);
    do_op("rd_b2b",    8'd9, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      do_op("rand", 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
    end
    go_idle();

    // Reset pulse between edges: output must clear without any clock.
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;
    #1 check("async_rst", bus.data_out, 32'h0);
    #1 rst_n = 1'b1;

    do_op("rd_5_rst",   8'd5,   1'b0, 32'h0);
    do_op("rd_255_rst", 8'd255, 1'b0, 32'h0);
    do_op("rd_3_rst",   8'd3,   1'b0, 32'h0);
    go_idle();

    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expected words never compared", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
